// File: rtl/zs_buffer_ctrl_if.sv
// Lookup and write-back channels between the depth/stencil test stage (master)
// and the depth/stencil buffer (slave).
interface zs_buffer_ctrl_if #(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned DEPTH_W   = 32,
  parameter int unsigned STENCIL_W = 8
) ();
  logic                 rd_valid;
  logic                 rd_ready;
  logic [COORD_W-1:0]   rd_x;
  logic [COORD_W-1:0]   rd_y;
  logic                 rd_data_valid;
  logic [DEPTH_W-1:0]   rd_depth;
  logic [STENCIL_W-1:0] rd_stencil;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [COORD_W-1:0]   wr_x;
  logic [COORD_W-1:0]   wr_y;
  logic                 wr_depth_en;
  logic [DEPTH_W-1:0]   wr_depth;
  logic                 wr_stencil_en;
  logic [STENCIL_W-1:0] wr_stencil;
  logic [STENCIL_W-1:0] stencil_write_mask;
  logic                 oob_drop;

  modport master (
    output rd_valid, rd_x, rd_y,
    input  rd_ready, rd_data_valid, rd_depth, rd_stencil,
    output wr_valid, wr_x, wr_y, wr_depth_en, wr_depth,
    output wr_stencil_en, wr_stencil, stencil_write_mask,
    input  wr_ready, oob_drop
  );

  modport slave (
    input  rd_valid, rd_x, rd_y,
    output rd_ready, rd_data_valid, rd_depth, rd_stencil,
    input  wr_valid, wr_x, wr_y, wr_depth_en, wr_depth,
    input  wr_stencil_en, wr_stencil, stencil_write_mask,
    output wr_ready, oob_drop
  );
endinterface

// File: rtl/zs_buffer_ctrl.sv
// Depth/stencil buffer: 1-cycle lookups, masked write-back, and a raster-order
// clear sweep that runs after reset or on request.
module zs_buffer_ctrl #(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned DEPTH_W   = 32,
  parameter int unsigned STENCIL_W = 8,
  parameter int unsigned SCREEN_W  = 16,
  parameter int unsigned SCREEN_H  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_start,
  input  logic [DEPTH_W-1:0]   clear_depth_val,
  input  logic [STENCIL_W-1:0] clear_stencil_val,
  output logic                 clear_busy,
  zs_buffer_ctrl_if.slave      bus
);
  localparam int unsigned PIXELS = SCREEN_W * SCREEN_H;
  localparam int unsigned ADDR_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return ADDR_W'(32'(y) * SCREEN_W + 32'(x));
  endfunction

  logic [DEPTH_W-1:0]   depth_mem   [PIXELS];
  logic [STENCIL_W-1:0] stencil_mem [PIXELS];

  state_t               state, state_next;
  logic [COORD_W-1:0]   sweep_x, sweep_y;
  logic                 sweep_x_last, sweep_last;
  logic [ADDR_W-1:0]    sweep_addr;
  logic [DEPTH_W-1:0]   clr_depth;
  logic [STENCIL_W-1:0] clr_stencil;

  logic                 rd_ready_i, wr_ready_i;
  logic                 rd_fire, wr_fire, rd_ok, wr_ok;
  logic [ADDR_W-1:0]    rd_addr, wr_addr;
  logic [DEPTH_W-1:0]   wr_depth_new;
  logic [STENCIL_W-1:0] wr_stencil_new;

  logic                 rd_data_valid_q, oob_drop_q;
  logic [DEPTH_W-1:0]   rd_depth_q;
  logic [STENCIL_W-1:0] rd_stencil_q;

  assign sweep_x_last = (32'(sweep_x) == SCREEN_W - 1);
  assign sweep_last   = sweep_x_last && (32'(sweep_y) == SCREEN_H - 1);
  assign sweep_addr   = pix_addr(sweep_x, sweep_y);

  assign rd_fire = bus.rd_valid && rd_ready_i;
  assign wr_fire = bus.wr_valid && wr_ready_i;
  assign rd_ok   = in_range(bus.rd_x, bus.rd_y);
  assign wr_ok   = in_range(bus.wr_x, bus.wr_y);
  assign rd_addr = rd_ok ? pix_addr(bus.rd_x, bus.rd_y) : '0;
  assign wr_addr = wr_ok ? pix_addr(bus.wr_x, bus.wr_y) : '0;

  // Post-write pixel contents; also serves the write-first read bypass.
  assign wr_depth_new   = bus.wr_depth_en ? bus.wr_depth : depth_mem[wr_addr];
  assign wr_stencil_new = bus.wr_stencil_en
                        ? ((stencil_mem[wr_addr] & ~bus.stencil_write_mask) |
                           (bus.wr_stencil & bus.stencil_write_mask))
                        : stencil_mem[wr_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_CLEAR;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_ready_i = 1'b0;
    wr_ready_i = 1'b0;
    clear_busy = 1'b0;
    case (state)
      S_IDLE: begin
        rd_ready_i = 1'b1;
        wr_ready_i = 1'b1;
        if (clear_start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        clear_busy = 1'b1;
        if (sweep_last) state_next = S_IDLE;
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_x     <= '0;
      sweep_y     <= '0;
      clr_depth   <= '1;
      clr_stencil <= '0;
    end else begin
      if (state == S_CLEAR) begin
        if (sweep_x_last) begin
          sweep_x <= '0;
          sweep_y <= sweep_last ? '0 : sweep_y + COORD_W'(1);
        end else begin
          sweep_x <= sweep_x + COORD_W'(1);
        end
      end
      if (state == S_IDLE && clear_start) begin
        clr_depth   <= clear_depth_val;
        clr_stencil <= clear_stencil_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      depth_mem[sweep_addr]   <= clr_depth;
      stencil_mem[sweep_addr] <= clr_stencil;
    end else if (wr_fire && wr_ok) begin
      if (bus.wr_depth_en)   depth_mem[wr_addr]   <= wr_depth_new;
      if (bus.wr_stencil_en) stencil_mem[wr_addr] <= wr_stencil_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_valid_q <= 1'b0;
      oob_drop_q      <= 1'b0;
      rd_depth_q      <= '0;
      rd_stencil_q    <= '0;
    end else begin
      rd_data_valid_q <= rd_fire;
      oob_drop_q      <= wr_fire && !wr_ok;
      if (rd_fire) begin
        if (!rd_ok) begin
          rd_depth_q   <= '1;
          rd_stencil_q <= '0;
        end else if (wr_fire && wr_ok && (wr_addr == rd_addr)) begin
          rd_depth_q   <= wr_depth_new;
          rd_stencil_q <= wr_stencil_new;
        end else begin
          rd_depth_q   <= depth_mem[rd_addr];
          rd_stencil_q <= stencil_mem[rd_addr];
        end
      end
    end
  end

  assign bus.rd_ready      = rd_ready_i;
  assign bus.wr_ready      = wr_ready_i;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_depth      = rd_depth_q;
  assign bus.rd_stencil    = rd_stencil_q;
  assign bus.oob_drop      = oob_drop_q;
endmodule

// File: doc/zs_buffer_ctrl.md
Name: zs_buffer_ctrl

Overview:
- Depth/stencil storage responder for the per-fragment depth/stencil test stage.
- The test stage issues a lookup (read) for each fragment's pixel. This block returns the stored depth and stencil values.
- It then accepts the write-back command (depth_write / stencil_write) produced after the test.
- It also owns a raster-order clear engine that initialises the whole buffer after reset or on request.

Parameters:
- COORD_W, 10, width of pixel x/y coordinates
- DEPTH_W, 32, depth value width
- STENCIL_W, 8, stencil value width
- SCREEN_W, 16, buffer width in pixels
- SCREEN_H, 16, buffer height in pixels

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- clear_start  in  1  one-cycle request to clear the entire buffer
- clear_depth_val  in  DEPTH_W  depth clear value, sampled on accepted clear_start
- clear_stencil_val  in  STENCIL_W  stencil clear value, sampled on accepted clear_start
- clear_busy  out  1  high while the clear sweep runs
- rd_valid  in  1  lookup request
- rd_ready  out  1  lookup accepted when rd_valid && rd_ready
- rd_x, rd_y  in  COORD_W  lookup pixel
- rd_data_valid  out  1  one-cycle pulse: rd_depth/rd_stencil valid
- rd_depth  out  DEPTH_W  stored depth
- rd_stencil  out  STENCIL_W  stored stencil
- wr_valid  in  1  write-back request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x, wr_y  in  COORD_W  write pixel
- wr_depth_en  in  1  write depth
- wr_depth  in  DEPTH_W  new depth
- wr_stencil_en  in  1  write stencil
- wr_stencil  in  STENCIL_W  new stencil
- stencil_write_mask  in  STENCIL_W  per-bit stencil write enable
- oob_drop  out  1  one-cycle pulse: accepted write had out-of-range coordinates

Behaviour:
- Reset (async, rst=0):
  - All outputs 0 except clear_busy=1.
  - FSM enters CLEAR with depth clear value all-ones and stencil clear value 0.
  - Sweep pointer is (0,0).
  - Reset asserted mid-operation aborts everything and restarts this default clear from pixel 0.
- FSM states:
  - IDLE → CLEAR on clear_start.
  - CLEAR → IDLE after the last pixel is written.
- CLEAR state:
  - Writes one pixel per cycle in raster order (x fastest), starting at (0,0) and ending at (SCREEN_W-1, SCREEN_H-1).
  - Takes exactly SCREEN_W*SCREEN_H cycles.
  - clear_busy=1, rd_ready=0, wr_ready=0.
  - The cycle after the final pixel is written: clear_busy=0, FSM in IDLE, ready lines high.
  - clear_start during CLEAR is ignored; the clear values are not resampled.
- IDLE state:
  - rd_ready=1, wr_ready=1.
  - clear_start is accepted in IDLE and latches clear_depth_val and clear_stencil_val.
  - clear_busy rises on the next cycle.
  - A read or write accepted in the same cycle as clear_start completes normally before the sweep.
- Read:
  - Latency 1: request accepted in cycle N gives rd_data_valid=1 with data in cycle N+1.
  - At most one request per cycle; full throughput of 1 per cycle.
  - rd_depth/rd_stencil hold their value when rd_data_valid=0.
- Write:
  - Takes effect at the clock edge of acceptance.
  - Depth is replaced if wr_depth_en.
  - If wr_stencil_en, stencil becomes (old & ~stencil_write_mask) | (wr_stencil & stencil_write_mask).
  - Write with both enables 0: no storage change, no error.
- Same-cycle read and write to the same pixel are write-first: the read returns the post-write values, including the masked stencil merge.
- Out of range means x >= SCREEN_W or y >= SCREEN_H:
  - Read returns depth all-ones and stencil 0, with rd_data_valid still pulsed.
  - Write is dropped and oob_drop pulses the cycle after acceptance.
- Arithmetic:
  - No arithmetic on stored values.
  - Address = y*SCREEN_W + x, computed only when in range.
  - Sweep counters wrap only at the defined end points.

Test Plan:
- Release reset → clear_busy=1 for exactly 256 cycles, ready lines 0 throughout. Then reading (5,7) gives rd_depth=32'hFFFFFFFF, rd_stencil=0 one cycle after acceptance.
- Write (3,4) depth=32'h1234, stencil=8'hAB, mask 8'hFF, then read (3,4) → rd_depth=32'h1234, rd_stencil=8'hAB with 1-cycle latency.
- Stored stencil 8'hAB; write stencil=8'h50, mask 8'h0F, wr_depth_en=0 → read returns stencil 8'hA0, depth unchanged.
- Same-cycle write (2,2) depth=32'h77 and read (2,2) → next-cycle rd_depth=32'h77. Back-to-back reads on consecutive cycles each return the correct data.
- Write to (16,0) → oob_drop pulse, no storage change. Read (0,20) → rd_depth=all-ones, rd_stencil=0.
- clear_start with clear_depth_val=32'h10, clear_stencil_val=8'h3 → after 256 busy cycles every pixel reads 32'h10/8'h3. Reset asserted at cycle 100 of that sweep → the default clear restarts and all pixels read all-ones/0.
